// File: rtl/vga_sync_detector_if.sv
// Sync-detector bundle: incoming hsync/vsync plus recovered timing outputs.
// Optional macro VGA_SYNC_MEASURE_EN adds the h_period/v_period measurement lines.
// master = sync source / consumer side, slave = detector.
interface vga_sync_detector_if;
  logic       hsync;
  logic       vsync;
  logic       locked;
  logic       frame_start;
  logic       timing_err;
  logic       is_blank;
  logic [9:0] row;
  logic [9:0] col;
`ifdef VGA_SYNC_MEASURE_EN
  logic [9:0] h_period;
  logic [9:0] v_period;

  modport master (output hsync, vsync,
                  input  locked, frame_start, timing_err, is_blank, row, col, h_period, v_period);
  modport slave  (input  hsync, vsync,
                  output locked, frame_start, timing_err, is_blank, row, col, h_period, v_period);
`else
  modport master (output hsync, vsync,
                  input  locked, frame_start, timing_err, is_blank, row, col);
  modport slave  (input  hsync, vsync,
                  output locked, frame_start, timing_err, is_blank, row, col);
`endif
endinterface

// File: rtl/vga_sync_detector.sv
// VGA sync detector: recovers pixel position/blanking from active-low hsync/vsync,
// checks timing against nominal values and locks after LOCK_FRAMES clean frames.
// Optional macro VGA_SYNC_MEASURE_EN: exposes last measured line/frame lengths.
module vga_sync_detector #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  vga_sync_detector_if.slave bus
);
  localparam logic [9:0]  H_AS   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]  H_AE   = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_AS   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  V_AE   = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [10:0] H_TOTW = 11'(H_TOTAL);
  localparam logic [10:0] H_SYNW = 11'(H_SYNC);
  localparam logic [10:0] V_TOTW = 11'(V_TOTAL);
  localparam logic [10:0] V_SYNW = 11'(V_SYNC);
  localparam logic [4:0]  LOCK_W = 5'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

  logic        hs1_q, hs2_q, vs1_q, vs2_q;
  logic [9:0]  hcount_q, hcount_d, vcount_q, vcount_d;
  logic        vw_pend_q, vw_pend_d;
  state_t      state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic        locked_q, fstart_q, terr_q;
  logic        hfall, hrise, vfall, err;
  logic        line_bad, hw_bad, frame_bad, vw_bad, tmo_bad, orphan_bad;
  logic [10:0] hcount_p1, vcount_p1;
  logic        blank;

  // Two-flop capture of the sync inputs; idle level is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs1_q <= 1'b1; hs2_q <= 1'b1; vs1_q <= 1'b1; vs2_q <= 1'b1;
    end else begin
      hs1_q <= bus.hsync; hs2_q <= hs1_q;
      vs1_q <= bus.vsync; vs2_q <= vs1_q;
    end
  end

  assign hfall     = !hs1_q &&  hs2_q;
  assign hrise     =  hs1_q && !hs2_q;
  assign vfall     = !vs1_q &&  vs2_q;
  assign hcount_p1 = {1'b0, hcount_q} + 11'd1;
  assign vcount_p1 = {1'b0, vcount_q} + 11'd1;

  // Position counters; vw_pend marks a vsync pulse whose width is still unchecked.
  always_comb begin
    hcount_d  = hfall ? '0 : ((hcount_q == 10'h3FF) ? hcount_q : hcount_q + 10'd1);
    vcount_d  = vcount_q;
    if (hfall) vcount_d = vfall ? '0 : ((vcount_q == 10'h3FF) ? vcount_q : vcount_q + 10'd1);
    vw_pend_d = vw_pend_q;
    if (vfall)               vw_pend_d = 1'b1;
    else if (hfall && vs1_q) vw_pend_d = 1'b0;
  end

  // vsync width is judged on the first line start seen with vsync already high:
  // vcount there still holds the last line index of the pulse.
  assign line_bad   = hfall && (hcount_p1 != H_TOTW);
  assign hw_bad     = hrise && (hcount_p1 != H_SYNW);
  assign frame_bad  = vfall && (vcount_p1 != V_TOTW);
  assign vw_bad     = hfall && !vfall && vw_pend_q && vs1_q && (vcount_p1 != V_SYNW);
  assign tmo_bad    = !hfall && (hcount_q == 10'h3FE);
  assign orphan_bad = vfall && !hfall;
  assign err        = (state_q != SEARCH) &&
                      (line_bad || hw_bad || frame_bad || vw_bad || tmo_bad || orphan_bad);

  // Lock FSM: next state and good-frame count.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      SEARCH: if (vfall) begin
        state_d = ACQUIRE;
        good_d  = '0;
      end
      ACQUIRE: begin
        if (err) state_d = SEARCH;
        else if (vfall) begin
          if ({1'b0, good_q} + 5'd1 >= LOCK_W) state_d = LOCKED;
          else                                 good_d  = good_q + 4'd1;
        end
      end
      LOCKED:  if (err) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  // Counters, FSM state and registered status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q  <= '0;
      vcount_q  <= '0;
      vw_pend_q <= 1'b0;
      state_q   <= SEARCH;
      good_q    <= '0;
      locked_q  <= 1'b0;
      fstart_q  <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      vw_pend_q <= vw_pend_d;
      state_q   <= state_d;
      good_q    <= good_d;
      locked_q  <= (state_q == LOCKED);
      fstart_q  <= vfall;
      terr_q    <= err;
    end
  end

  assign blank = (vcount_q < V_AS) || (vcount_q >= V_AE) ||
                 (hcount_q < H_AS) || (hcount_q >= H_AE);

  assign bus.locked      = locked_q;
  assign bus.frame_start = fstart_q;
  assign bus.timing_err  = terr_q;
  assign bus.is_blank    = !locked_q || blank;
  assign bus.row         = locked_q ? vcount_q - V_AS : '0;
  assign bus.col         = (locked_q && !blank) ? hcount_q - H_AS : '0;

`ifdef VGA_SYNC_MEASURE_EN
  logic [9:0] hper_q, vper_q;

  // Last measured line/frame lengths, saturating, updated in every state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hper_q <= '0;
      vper_q <= '0;
    end else begin
      if (hfall) hper_q <= hcount_p1[10] ? 10'h3FF : hcount_p1[9:0];
      if (vfall) vper_q <= vcount_p1[10] ? 10'h3FF : vcount_p1[9:0];
    end
  end

  assign bus.h_period = hper_q;
  assign bus.v_period = vper_q;
`endif
endmodule

// File: tb/tb_vga_sync_detector.sv
// Directed bench for vga_sync_detector using a scaled-down timing (48x24 totals)
// so several lock/unlock cycles fit in a short run.
module tb_vga_sync_detector;
  localparam int HT = 48, HS = 6, HB = 6, HA = 32;
  localparam int VT = 24, VS = 2, VB = 3, VA = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vga_sync_detector_if bus();

  vga_sync_detector #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_cmp = 0, n_bad = 0;
  int src_h, src_v, vs_w;
  bit freeze = 1'b0, stretch = 1'b0;
  int n_fs = 0, n_te = 0, fs_age = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One source clock: tally DUT pulses, then advance the sync generator.
  task automatic step();
    @(negedge clk);
    if (bus.frame_start) begin n_fs++; fs_age = 0; end
    else fs_age++;
    if (bus.timing_err) n_te++;
    if (!freeze) begin
      if (stretch) stretch = 1'b0;
      else begin
        src_h++;
        if (src_h == HT) begin
          src_h = 0;
          src_v = (src_v + 1) % VT;
        end
      end
    end
    bus.hsync = (src_h >= HS);
    bus.vsync = (src_v >= vs_w);
  endtask

  task automatic advance_to(input int h, input int v);
    bit hit = 1'b0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      step();
      if (src_h == h && src_v == v) begin hit = 1'b1; break; end
    end
    if (!hit) chk("advance_timeout", 0, 1);
  endtask

  // Present (h,v) and let it propagate through the 2-clock recovery latency.
  task automatic goto(input int h, input int v);
    advance_to(h, v);
    step();
    step();
  endtask

  task automatic wait_lock(input string tag);
    int fs0, te0;
    bit ok;
    fs0 = n_fs; te0 = n_te; ok = 1'b0;
    for (int i = 0; i < 6 * HT * VT; i++) begin
      step();
      if (bus.locked) begin ok = 1'b1; break; end
    end
    chk({tag, "_locked"}, int'(ok), 1);
    chk({tag, "_fs_to_lock"}, n_fs - fs0, 3);
    chk({tag, "_lock_lat"}, fs_age, 1);
    chk({tag, "_no_err"}, n_te - te0, 0);
  endtask

  task automatic chk_dec(input string tag, input int blank, input int row, input int col);
    chk({tag, "_blank"}, int'(bus.is_blank), blank);
    chk({tag, "_row"}, int'(bus.row), row);
    chk({tag, "_col"}, int'(bus.col), col);
  endtask

  initial begin
    int te0;
    src_h = 30; src_v = 12; vs_w = VS;
    bus.hsync = 1'b1; bus.vsync = 1'b1;

    // reset state
    repeat (4) step();
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_fstart", int'(bus.frame_start), 0);
    chk("rst_terr", int'(bus.timing_err), 0);
    chk_dec("rst", 1, 0, 0);
`ifdef VGA_SYNC_MEASURE_EN
    chk("rst_hper", int'(bus.h_period), 0);
    chk("rst_vper", int'(bus.v_period), 0);
`endif
    reset_n = 1'b1;

    // nominal acquisition from mid-frame
    wait_lock("acq");

    // decode boundaries: active area starts at h=12, v=5; ends h=43, v=20
    goto(12, 5);  chk_dec("first_px", 0, 0, 0);
    goto(43, 5);  chk_dec("last_px", 0, 0, 31);
    goto(44, 5);  chk_dec("hfront", 1, 0, 0);
    goto(20, 20); chk_dec("last_line", 0, 15, 8);
    goto(20, 21); chk_dec("vfront", 1, 16, 0);
    goto(20, 2);  chk_dec("vback", 1, 1021, 0);

    // one 49-clock line
    advance_to(HT - 1, 10);
    te0 = n_te;
    stretch = 1'b1;
    repeat (2 * HT) step();
    chk("long_line_err", n_te - te0, 1);
    chk("long_line_unlock", int'(bus.locked), 0);
    wait_lock("relock1");

    // hsync stuck high -> hcount timeout
    advance_to(20, 10);
    te0 = n_te;
    freeze = 1'b1;
    repeat (1100) step();
    chk("tmo_err", n_te - te0, 1);
    chk("tmo_unlock", int'(bus.locked), 0);
    chk_dec("tmo", 1, 0, 0);
    freeze = 1'b0;
    wait_lock("relock2");

    // 3-line vsync pulse
    advance_to(0, VT - 1);
    te0 = n_te;
    vs_w = 3;
    advance_to(0, 10);
    vs_w = VS;
    chk("vsw_err", n_te - te0, 1);
    chk("vsw_unlock", int'(bus.locked), 0);
    wait_lock("relock3");

    // asynchronous reset while locked
    advance_to(20, 10);
    reset_n = 1'b0;
    #1;
    chk("arst_locked", int'(bus.locked), 0);
    chk("arst_blank", int'(bus.is_blank), 1);
`ifdef VGA_SYNC_MEASURE_EN
    chk("arst_hper", int'(bus.h_period), 0);
`endif
    repeat (3) step();
    reset_n = 1'b1;
    wait_lock("relock4");
`ifdef VGA_SYNC_MEASURE_EN
    chk("meas_hper", int'(bus.h_period), HT);
    chk("meas_vper", int'(bus.v_period), VT);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
